// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// grant-id encoding and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin tie-breaker (purely combinational).
// Ports:
//   req[1:0]   - request vector, bit 0 = IF, bit 1 = LS
//   last_grant - requester granted most recently
//   gnt_valid  - at least one requester is asking
//   gnt_id     - selected requester
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_e       last_grant,
  output logic       gnt_valid,
  output gnt_e       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_IF;
    if (req[0] && req[1]) begin
      // Tie: favour whoever did not win last time.
      gnt_id = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (req[1]) begin
      gnt_id = GNT_LS;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between an instruction-fetch (read-only) and a
// load/store requester. One access in flight at a time; each access ends
// with a one-cycle RESP state so the served requester can drop valid before
// the next arbitration.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   if_valid/if_addr               - fetch request (held until if_done)
//   if_done/if_rdata               - fetch completion pulse and held data
//   ls_valid/ls_we/ls_addr/ls_wdata- load/store request (held until ls_done)
//   ls_done/ls_rdata               - load/store completion and held load data
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//   mem_rdata/mem_ready            - memory response
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_valid,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  state_e                state_q, state_d;
  gnt_e                  last_grant_q, last_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

  logic gnt_valid;
  gnt_e gnt_id;

  arb_rr2 u_arb (
    .req        ({ls_valid, if_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          mem_req_d    = 1'b1;
          last_grant_d = gnt_id;
          if (gnt_id == GNT_LS) begin
            state_d     = BUSY_LS;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
          end else begin
            // Fetch: write data is left as-is, it is don't-care on reads.
            state_d    = BUSY_IF;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
        end
      end
      BUSY_LS: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) ls_rdata_d = mem_rdata;
          ls_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;  // RESP: never grants, lets valid drop
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_LS;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed single-access table, hand sequences for
// arbitration / reset / ignored-ready corners, then randomized traffic
// scored against a transaction-level memory and fairness model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, ls_valid, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, rdata_drv;
  logic        if_done, ls_done, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        use_model;
  logic [31:0] mem_arr [16];
  logic [31:0] gold    [16];

  assign mem_rdata = use_model ? mem_arr[mem_addr[5:2]] : rdata_drv;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_dones", {if_done, ls_done}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // BUSY cycles with mem_ready low
    logic        exp_we;
    logic [31:0] exp_rdata;  // requester's rdata after done
  } vec_t;

  task automatic run_single(input vec_t v);
    if (v.is_ls) begin
      ls_valid = 1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_valid = 1; if_addr = v.addr;
    end
    mem_ready = 0; rdata_drv = v.rdata;
    tick();
    chk("grant_req", mem_req, 1);
    chk("grant_addr", mem_addr, v.addr);
    chk("grant_we", mem_we, v.exp_we);
    if (v.is_ls && v.we) chk("grant_wdata", mem_wdata, v.wdata);
    for (int i = 0; i < v.delay; i++) begin
      tick();
      chk("busy_req", mem_req, 1);
      chk("busy_addr", mem_addr, v.addr);
      chk("busy_we", mem_we, v.exp_we);
      if (v.is_ls && v.we) chk("busy_wdata", mem_wdata, v.wdata);
      chk("busy_nodone", {if_done, ls_done}, 0);
    end
    mem_ready = 1;
    tick();
    chk("done_pulse", {if_done, ls_done}, v.is_ls ? 2'b01 : 2'b10);
    chk("done_req_drop", {mem_req, mem_we}, 0);
    chk("done_rdata", v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    mem_ready = 0; if_valid = 0; ls_valid = 0;
    tick();
    chk("resp_nodone", {if_done, ls_done}, 0);
    chk("resp_noreq", mem_req, 0);
    tick();
    chk("idle_noreq", mem_req, 0);
  endtask

  vec_t tbl[5];
  logic [31:0] grants[8];
  int ng;
  logic pr;

  // random-phase state
  logic        bf_act[2], bf_we[2];
  int          bf_dly[2], bf_age[2];
  logic [3:0]  bf_idx[2];
  logic [31:0] bf_dat[2];
  logic        p_req, p_rdy, p_we, p_ifv, p_lsv, tb_last;
  logic [31:0] p_addr, p_wdata, exp_ls;
  int          owner, r, g;

  initial begin
    use_model = 0;
    if_valid = 0; ls_valid = 0; ls_we = 0; mem_ready = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; rdata_drv = 0;
    do_reset();

    tbl[0] = '{1'b0, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h2000,     32'h12345678, 32'hBAD0BAD0, 3, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h3000,     32'h0,        32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 1'b1, 32'h44,       32'h1,        32'hFFFFFFFF, 0, 1'b1, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        2, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) run_single(tbl[i]);

    // Both held after reset: IF, LS, IF, LS with 3 edges per access.
    do_reset();
    if_valid = 1; if_addr = 32'h10;
    ls_valid = 1; ls_we = 0; ls_addr = 32'h20;
    mem_ready = 1; rdata_drv = 32'h55;
    ng = 0; pr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("tie_excl", {31'b0, if_done & ls_done}, 0);
      if (mem_req && !pr && ng < 8) begin grants[ng] = mem_addr; ng++; end
      pr = mem_req;
    end
    chk("tie_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("tie_order", grants[i], (i % 2) ? 32'h20 : 32'h10);
    if_valid = 0; ls_valid = 0; mem_ready = 0;
    tick(); tick();

    // LS arrives while IF busy: granted right after the mandatory IDLE.
    if_valid = 1; if_addr = 32'h10; mem_ready = 1;
    tick();
    chk("b_if_grant", mem_addr, 32'h10);
    ls_valid = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'hA5A5;
    tick();
    chk("b_if_done", if_done, 1);
    if_valid = 0;
    tick();
    chk("b_idle_gap", {mem_req, if_done, ls_done}, 0);
    tick();
    chk("b_ls_grant", {mem_req, mem_we}, 2'b11);
    chk("b_ls_addr", mem_addr, 32'h20);
    tick();
    chk("b_ls_done", ls_done, 1);
    ls_valid = 0; mem_ready = 0;
    tick(); tick();

    // Reset mid-BUSY: immediate drop, no done.
    if_valid = 1; if_addr = 32'h30;
    tick();
    chk("c_busy", mem_req, 1);
    #2 rst = 1;
    #1;
    chk("c_async_req", mem_req, 0);
    chk("c_async_addr", mem_addr, 0);
    mem_ready = 1;
    tick();
    chk("c_nodone_rst", {mem_req, if_done, ls_done}, 0);
    rst = 0; if_valid = 0; mem_ready = 0;
    tick();
    chk("c_nodone_after", {if_done, ls_done}, 0);
    run_single('{1'b0, 1'b0, 32'h40, 32'h0, 32'h77, 1, 1'b0, 32'h77});

    // mem_ready ignored in IDLE and in RESP.
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_idle_ready", {mem_req, if_done, ls_done}, 0);
    end
    if_valid = 1; if_addr = 32'h50;
    tick();
    tick();
    chk("d_done", if_done, 1);
    if_valid = 0;
    tick();
    chk("d_resp_ready", {mem_req, if_done, ls_done}, 0);
    tick();
    chk("d_idle2", {mem_req, if_done, ls_done}, 0);
    mem_ready = 0;

    // Randomized traffic against a memory/fairness scoreboard.
    do_reset();
    use_model = 1;
    for (int i = 0; i < 16; i++) begin mem_arr[i] = $urandom; gold[i] = mem_arr[i]; end
    for (int i = 0; i < 2; i++) begin
      bf_act[i] = 0; bf_we[i] = 0; bf_dly[i] = 0; bf_age[i] = 0; bf_idx[i] = 0; bf_dat[i] = 0;
    end
    p_req = 0; p_rdy = 0; p_we = 0; p_ifv = 0; p_lsv = 0; p_addr = 0; p_wdata = 0;
    tb_last = 1; exp_ls = 0; owner = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("r_done_excl", {31'b0, if_done & ls_done}, 0);
      if (if_done || ls_done) begin
        r = if_done ? 0 : 1;
        chk("r_done_after_ready", {31'b0, p_req & p_rdy}, 1);
        chk("r_done_owner", r, owner);
        chk("r_req_drop", mem_req, 0);
        if (r == 0) chk("r_if_rdata", if_rdata, gold[bf_idx[0]]);
        else if (bf_we[1]) begin
          gold[bf_idx[1]] = bf_dat[1];
          chk("r_st_ls_hold", ls_rdata, exp_ls);
        end else begin
          exp_ls = gold[bf_idx[1]];
          chk("r_ld_rdata", ls_rdata, exp_ls);
        end
        bf_act[r] = 0; bf_dly[r] = $urandom_range(0, 3); owner = -1;
      end else if (p_req && p_rdy) chk("r_done_missing", {31'b0, if_done | ls_done}, 1);
      if (p_req && !p_rdy) begin
        chk("r_hold_req", mem_req, 1);
        chk("r_hold_addr", mem_addr, p_addr);
        chk("r_hold_we", mem_we, p_we);
        chk("r_hold_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && !p_req) begin
        chk("r_grant_has_req", {31'b0, p_ifv | p_lsv}, 1);
        g = (p_ifv && p_lsv) ? (tb_last ? 0 : 1) : (p_lsv ? 1 : 0);
        tb_last = g[0]; owner = g;
        chk("r_grant_addr", mem_addr, (g == 1) ? {26'b0, bf_idx[1], 2'b0}
                                                : (32'h1000 | {26'b0, bf_idx[0], 2'b0}));
        chk("r_grant_we", mem_we, (g == 1) ? bf_we[1] : 1'b0);
        if (g == 1 && bf_we[1]) chk("r_grant_wdata", mem_wdata, bf_dat[1]);
      end
      if (p_req && p_rdy && p_we) mem_arr[p_addr[5:2]] = p_wdata;
      for (int k = 0; k < 2; k++) begin
        if (bf_act[k]) begin
          bf_age[k]++;
          if (bf_age[k] > 300) begin
            checks++; failures++;
            $display("FAIL r_timeout: requester %0d waited %0d cycles, limit 300", k, bf_age[k]);
            bf_act[k] = 0;
          end
        end else if (bf_dly[k] > 0) bf_dly[k]--;
        else if ($urandom_range(0, 1) == 1) begin
          bf_act[k] = 1; bf_age[k] = 0; bf_idx[k] = 4'($urandom_range(0, 15));
          bf_we[k] = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          bf_dat[k] = $urandom;
        end
      end
      if_valid = bf_act[0]; if_addr = 32'h1000 | {26'b0, bf_idx[0], 2'b0};
      ls_valid = bf_act[1]; ls_we = bf_we[1]; ls_addr = {26'b0, bf_idx[1], 2'b0};
      ls_wdata = bf_dat[1];
      mem_ready = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we; p_addr = mem_addr;
      p_wdata = mem_wdata; p_ifv = if_valid; p_lsv = ls_valid;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data buses.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_valid  input  1  instruction-fetch read request; held until if_done.
REQ-006 if_addr  input  ADDR_WIDTH  instruction-fetch read address.
REQ-007 if_done  output  1  one-cycle pulse: fetch access complete, if_rdata valid.
REQ-008 if_rdata  output  DATA_WIDTH  fetched word; holds its value until the next fetch completes.
REQ-009 ls_valid  input  1  load/store request; held until ls_done.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  ADDR_WIDTH  load/store address.
REQ-012 ls_wdata  input  DATA_WIDTH  store data.
REQ-013 ls_done  output  1  one-cycle pulse: load/store complete, ls_rdata valid for loads.
REQ-014 ls_rdata  output  DATA_WIDTH  load result; holds its value until the next load completes.
REQ-015 mem_req  output  1  memory access in progress.
REQ-016 mem_we  output  1  write enable for the current access.
REQ-017 mem_addr  output  ADDR_WIDTH  current access address.
REQ-018 mem_wdata  output  DATA_WIDTH  current write data.
REQ-019 mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready is high.
REQ-020 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-021 The FSM SHALL have four states: IDLE, BUSY_IF, BUSY_LS and RESP.
REQ-022 In IDLE, if only one requester is valid, the FSM SHALL grant that requester at the next edge.
REQ-023 In IDLE, if both requesters are valid, the FSM SHALL grant the requester that was not granted last (round-robin); the last_grant bit updates on every grant.
REQ-024 On a grant, the FSM SHALL register mem_req=1 together with the selected mem_we, mem_addr and mem_wdata. For fetches, mem_we=0 and mem_wdata is don't-care.
REQ-025 These memory outputs SHALL stay stable until the access completes.
REQ-026 In BUSY_IF or BUSY_LS with mem_ready=1, the FSM SHALL go to RESP at the next edge, performing these actions at that edge:
- drop mem_req and mem_we;
- capture mem_rdata into the granted requester's rdata register (loads and fetches only);
- pulse that requester's done for exactly one cycle.
REQ-027 RESP SHALL always return to IDLE at the next edge with no new grant. This gives the requester one cycle to deassert valid.
REQ-028 Minimum latency SHALL be as follows: request sampled at edge N, mem_req high after N, mem_ready in cycle N+1, done high in cycle N+2, next grant no earlier than edge N+3.
REQ-029 The FSM SHALL ignore mem_ready while in IDLE or RESP.
REQ-030 The FSM SHALL ignore changes on the granted requester's valid, address or data during BUSY. The access completes, and done still pulses.
REQ-031 The FSM SHALL wait indefinitely in BUSY for mem_ready. There is no timeout.
REQ-032 The block SHALL never assert if_done and ls_done in the same cycle, and SHALL never change mem_addr while mem_req is high.

Reset
REQ-033 When rst is high, the block SHALL immediately force the following, independent of clk:
- state = IDLE;
- mem_req, mem_we, if_done and ls_done = 0;
- mem_addr, mem_wdata, if_rdata and ls_rdata = 0;
- last_grant = LS, so that the first tie grants IF.
REQ-034 Reset asserted during BUSY SHALL abort the access with no done pulse.

Structure
REQ-035 The state encoding, grant-id encoding (IF=0, LS=1) and width defaults SHALL be defined in a shared package mem_arb_pkg.
REQ-036 Tie-breaking SHALL be implemented in one combinational sub-module, arb_rr2, with inputs req[1:0] and last_grant, and outputs gnt_valid and gnt_id.

Verification
REQ-037 IF only: if_valid=1, if_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, if_done pulses once, if_rdata=0xDEADBEEF.
REQ-038 Store only: ls_we=1, ls_addr=0x2000, ls_wdata=0x12345678, mem_ready after 3 BUSY cycles -> mem_we=1 with stable address and data for 3 cycles, then a single ls_done pulse, ls_rdata unchanged.
REQ-039 Simultaneous requests, first after reset -> IF granted first, then LS. Repeat with both held -> grants alternate IF, LS, IF, LS.
REQ-040 LS request arrives while BUSY_IF -> LS granted at the first IDLE after RESP, with no gap beyond the mandatory IDLE cycle.
REQ-041 rst asserted mid-BUSY -> mem_req low without a clock edge, no done pulse. After release, a new request is served normally.
REQ-042 mem_ready pulsed in IDLE and in RESP -> no state change and no done pulse.
